// File: rtl/ppu_frame_timer.sv
// Dot/scanline sequencer: x/y counters, region decodes, line/frame strobes, PPUSTATUS vblank flag and NMI.
// Build macro ODD_FRAME_SKIP_EN: drop the last pre-render dot on odd frames while rendering is enabled.
module ppu_frame_timer #(
  parameter int H_TOTAL   = 341,
  parameter int H_VISIBLE = 256,
  parameter int V_VISIBLE = 240,
  parameter int V_POST    = 1,
  parameter int V_TOTAL   = 262,
  parameter int X_W       = 9,
  parameter int Y_W       = 9
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           pix_ce,
  input  logic           rendering_en,
  input  logic           nmi_en,
  input  logic           status_rd,
  output logic [X_W-1:0] x_idx,
  output logic [Y_W-1:0] y_idx,
  output logic           render,
  output logic           hblank,
  output logic           vblank,
  output logic           prerender,
  output logic           line_start,
  output logic           frame_start,
  output logic           vblank_flag,
  output logic           nmi,
  output logic           odd_frame
);

  localparam logic [X_W-1:0] X_LAST = X_W'(H_TOTAL - 1);
  localparam logic [X_W-1:0] X_VIS  = X_W'(H_VISIBLE);
  localparam logic [X_W-1:0] X_ONE  = X_W'(1);
  localparam logic [Y_W-1:0] Y_LAST = Y_W'(V_TOTAL - 1);
  localparam logic [Y_W-1:0] Y_VIS  = Y_W'(V_VISIBLE);
  localparam logic [Y_W-1:0] Y_VBL  = Y_W'(V_VISIBLE + V_POST);

  logic [X_W-1:0] x_q, x_d;
  logic [Y_W-1:0] y_q, y_d;
  logic           odd_q, odd_d;
  logic           render_q, render_d;
  logic           hblank_q, hblank_d;
  logic           vblank_q, vblank_d;
  logic           prerender_q, prerender_d;
  logic           line_start_q, line_start_d;
  logic           frame_start_q, frame_start_d;
  logic           vblank_flag_q, vblank_flag_d;
  logic           nmi_q, nmi_d;
  logic           skip_dot;
  logic           vbl_set;
  logic           vbl_clr;

`ifdef ODD_FRAME_SKIP_EN
  localparam logic [X_W-1:0] X_SKIP = X_W'(H_TOTAL - 2);
  assign skip_dot = odd_q && rendering_en && (y_q == Y_LAST) && (x_q == X_SKIP);
`else
  assign skip_dot = 1'b0;
`endif

  always_comb begin
    x_d   = x_q;
    y_d   = y_q;
    odd_d = odd_q;
    if (pix_ce) begin
      if (skip_dot || (x_q == X_LAST)) begin
        x_d = '0;
        if (skip_dot || (y_q == Y_LAST)) begin
          y_d   = '0;
          odd_d = ~odd_q;
        end else begin
          y_d = y_q + 1'b1;
        end
      end else begin
        x_d = x_q + 1'b1;
      end
    end
  end

  // Decodes use the next count so the registered outputs line up with x_idx/y_idx.
  always_comb begin
    render_d      = rendering_en && (y_d < Y_VIS) && (x_d < X_VIS);
    hblank_d      = (x_d >= X_VIS);
    vblank_d      = (y_d >= Y_VBL) && (y_d < Y_LAST);
    prerender_d   = (y_d == Y_LAST);
    line_start_d  = pix_ce && (x_d == '0);
    frame_start_d = line_start_d && (y_d == '0);
    vbl_set       = pix_ce && (x_d == X_ONE) && (y_d == Y_VBL);
    vbl_clr       = pix_ce && (x_d == X_ONE) && (y_d == Y_LAST);
  end

  // A status read landing on the set edge wins, so that frame never raises the flag.
  always_comb begin
    vblank_flag_d = vblank_flag_q;
    if (status_rd) begin
      vblank_flag_d = 1'b0;
    end else if (vbl_set) begin
      vblank_flag_d = 1'b1;
    end else if (vbl_clr) begin
      vblank_flag_d = 1'b0;
    end
    nmi_d = vblank_flag_q && nmi_en;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      x_q           <= '0;
      y_q           <= '0;
      odd_q         <= 1'b0;
      render_q      <= 1'b0;
      hblank_q      <= 1'b0;
      vblank_q      <= 1'b0;
      prerender_q   <= 1'b0;
      line_start_q  <= 1'b0;
      frame_start_q <= 1'b0;
      vblank_flag_q <= 1'b0;
      nmi_q         <= 1'b0;
    end else begin
      x_q           <= x_d;
      y_q           <= y_d;
      odd_q         <= odd_d;
      render_q      <= render_d;
      hblank_q      <= hblank_d;
      vblank_q      <= vblank_d;
      prerender_q   <= prerender_d;
      line_start_q  <= line_start_d;
      frame_start_q <= frame_start_d;
      vblank_flag_q <= vblank_flag_d;
      nmi_q         <= nmi_d;
    end
  end

  assign x_idx       = x_q;
  assign y_idx       = y_q;
  assign render      = render_q;
  assign hblank      = hblank_q;
  assign vblank      = vblank_q;
  assign prerender   = prerender_q;
  assign line_start  = line_start_q;
  assign frame_start = frame_start_q;
  assign vblank_flag = vblank_flag_q;
  assign nmi         = nmi_q;
  assign odd_frame   = odd_q;

endmodule

// File: tb/tb_ppu_frame_timer.sv
// Directed bench for ppu_frame_timer on a shrunken raster: 8 dots x 5 lines, 40-dot frame,
// vblank line y=3, pre-render line y=4.
module tb_ppu_frame_timer;

  localparam int HT = 8;
  localparam int HV = 4;
  localparam int VV = 2;
  localparam int VP = 1;
  localparam int VT = 5;
  localparam int XW = 4;
  localparam int YW = 4;

`ifdef ODD_FRAME_SKIP_EN
  localparam int SKIP = 1;
`else
  localparam int SKIP = 0;
`endif

  logic          clk = 1'b0;
  logic          reset;
  logic          pix_ce;
  logic          rendering_en;
  logic          nmi_en;
  logic          status_rd;
  logic [XW-1:0] x_idx;
  logic [YW-1:0] y_idx;
  logic          render, hblank, vblank, prerender;
  logic          line_start, frame_start, vblank_flag, nmi, odd_frame;

  int n_chk  = 0;
  int n_pass = 0;
  int f_len, f_ren, f_hb, f_vb, f_pre, f_ls;
  int set_x, set_y, clr_x, clr_y;

  always #5 clk = ~clk;

  ppu_frame_timer #(
    .H_TOTAL(HT), .H_VISIBLE(HV), .V_VISIBLE(VV), .V_POST(VP), .V_TOTAL(VT),
    .X_W(XW), .Y_W(YW)
  ) dut (
    .clk(clk), .reset(reset), .pix_ce(pix_ce), .rendering_en(rendering_en),
    .nmi_en(nmi_en), .status_rd(status_rd), .x_idx(x_idx), .y_idx(y_idx),
    .render(render), .hblank(hblank), .vblank(vblank), .prerender(prerender),
    .line_start(line_start), .frame_start(frame_start), .vblank_flag(vblank_flag),
    .nmi(nmi), .odd_frame(odd_frame)
  );

  task automatic check_eq(input string tag, input int got, input int exp);
    n_chk++;
    if (got == exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic step();
    @(negedge clk);
  endtask

  task automatic wait_pos(input int wx, input int wy, input string tag);
    int n = 0;
    while (!((int'(x_idx) == wx) && (int'(y_idx) == wy)) && n < 200) begin
      step();
      n++;
    end
    check_eq(tag, ((int'(x_idx) == wx) && (int'(y_idx) == wy)) ? 1 : 0, 1);
  endtask

  // Called while frame_start is displayed; samples every dot until the next frame_start.
  task automatic run_frame();
    logic prev_flag;
    f_len = 0; f_ren = 0; f_hb = 0; f_vb = 0; f_pre = 0; f_ls = 0;
    set_x = -1; set_y = -1; clr_x = -1; clr_y = -1;
    prev_flag = vblank_flag;
    do begin
      f_ren += int'(render);
      f_hb  += int'(hblank);
      f_vb  += int'(vblank);
      f_pre += int'(prerender);
      f_ls  += int'(line_start);
      if (vblank_flag && !prev_flag) begin set_x = int'(x_idx); set_y = int'(y_idx); end
      if (!vblank_flag && prev_flag) begin clr_x = int'(x_idx); clr_y = int'(y_idx); end
      prev_flag = vblank_flag;
      step();
      f_len++;
    end while (!frame_start && f_len < 100);
  endtask

  initial begin
    int n;
    int held_bad;
    int prev_x, prev_y;
    logic flag_seen, nmi_seen;

    reset = 1'b0; pix_ce = 1'b0; rendering_en = 1'b1; nmi_en = 1'b0; status_rd = 1'b0;
    step(); step();
    check_eq("por_xy", int'({x_idx, y_idx}), 0);
    check_eq("por_outs", int'({render, hblank, vblank, prerender, line_start, frame_start,
                               vblank_flag, nmi, odd_frame}), 0);

    reset = 1'b1; pix_ce = 1'b1;
    repeat (21) step();
    check_eq("run_x", int'(x_idx), 5);
    check_eq("run_y", int'(y_idx), 2);

    reset = 1'b0;
    repeat (3) step();
    check_eq("midrst_xy", int'({x_idx, y_idx}), 0);
    check_eq("midrst_outs", int'({render, hblank, vblank, prerender, line_start, frame_start,
                                  vblank_flag, nmi, odd_frame}), 0);
    reset = 1'b1;
    step();
    check_eq("release_x", int'(x_idx), 1);
    check_eq("release_fs", int'(frame_start), 0);
    n = 0;
    while (!frame_start && n < 100) begin step(); n++; end
    check_eq("first_fs_dist", n, 39);
    check_eq("first_fs_pos", int'({x_idx, y_idx}), 0);
    check_eq("odd_after_wrap", int'(odd_frame), 1);

    // Odd frame, rendering on: the only frame that may be shortened.
    run_frame();
    check_eq("a_len", f_len, 40 - SKIP);
    check_eq("a_render", f_ren, 8);
    check_eq("a_hblank", f_hb, 20 - SKIP);
    check_eq("a_vblank", f_vb, 8);
    check_eq("a_prerender", f_pre, 8 - SKIP);
    check_eq("a_line_start", f_ls, 5);
    check_eq("a_set_x", set_x, 1);
    check_eq("a_set_y", set_y, 3);
    check_eq("a_clr_x", clr_x, 1);
    check_eq("a_clr_y", clr_y, 4);
    check_eq("a_odd_next", int'(odd_frame), 0);

    rendering_en = 1'b0;
    run_frame();
    check_eq("b_len", f_len, 40);
    check_eq("b_odd_next", int'(odd_frame), 1);
    run_frame();
    check_eq("c_len_odd_norender", f_len, 40);
    check_eq("c_render", f_ren, 0);

    // Dot enable every 4th clock: state must hold and strobes stay low in between.
    n = 0; held_bad = 0; prev_x = int'(x_idx); prev_y = int'(y_idx);
    do begin
      pix_ce = ((n % 4) == 3);
      step();
      n++;
      if ((n % 4) != 0) begin
        if (int'(x_idx) != prev_x || int'(y_idx) != prev_y || line_start || frame_start)
          held_bad++;
      end
      prev_x = int'(x_idx);
      prev_y = int'(y_idx);
    end while (!frame_start && n < 400);
    check_eq("ce4_period", n, 160);
    check_eq("ce4_hold", held_bad, 0);
    pix_ce = 1'b1;

    // Status read on the very edge that would set the flag.
    nmi_en = 1'b1;
    wait_pos(0, 3, "race_pos");
    status_rd = 1'b1;
    step();
    status_rd = 1'b0;
    check_eq("race_flag", int'(vblank_flag), 0);
    flag_seen = 1'b0; nmi_seen = 1'b0; n = 0;
    while (!frame_start && n < 100) begin
      flag_seen |= vblank_flag;
      nmi_seen  |= nmi;
      step();
      n++;
    end
    check_eq("race_flag_frame", int'(flag_seen), 0);
    check_eq("race_nmi_frame", int'(nmi_seen), 0);

    // Late NMI enable during vblank, then acknowledge by status read.
    nmi_en = 1'b0;
    wait_pos(0, 3, "late_pos");
    step();
    check_eq("late_flag_set", int'(vblank_flag), 1);
    check_eq("late_nmi_off", int'(nmi), 0);
    wait_pos(4, 3, "late_pos2");
    check_eq("late_nmi_still_off", int'(nmi), 0);
    nmi_en = 1'b1;
    step();
    check_eq("late_nmi_on", int'(nmi), 1);
    status_rd = 1'b1;
    step();
    status_rd = 1'b0;
    check_eq("ack_flag", int'(vblank_flag), 0);
    step();
    check_eq("ack_nmi", int'(nmi), 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
